ex_stage_md: RTL
================

Name: ex_stage_md

Overview:
Parametrised execute stage for the 5-stage pipeline. It sits between the ID/EX and EX/MEM registers. It performs operand forwarding and operand selection, and runs a single-cycle ALU. It also contains an iterative multiply/divide unit with HI/LO registers, which stalls upstream through ex_busy while an operation is in flight.

Parameters:
DATA_W, 32, datapath width (≥8, even)
REG_AW, 5, register-address width
CNT_W, 6, iteration-counter width (≥ clog2(DATA_W)+1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of the EX instruction (branch/exception)
id_valid  in  1  ID/EX holds a real instruction
rs_data, rt_data  in  DATA_W  register operands
fwd_a, fwd_b  in  2  10=EX/MEM ALU out, 01=mem_fwd_data, else register operand
mem_fwd_data  in  DATA_W  MEM/WB forward value
src1_sel  in  1  1 = zero-extended shamt as operand 1
src2_sel  in  1  1 = imm as operand 2
imm  in  DATA_W  extended immediate
shamt  in  5  shift amount
op  in  5  ADD,SUB,AND,OR,XOR,NOR,SLT,SLTU,SLL,SRL,SRA,MULT,MULTU,DIV,DIVU,MFHI,MFLO
pc_plus_4  in  DATA_W  link value
reg_write, mem_read, mem_write, fwd_mem  in  1  control to pass through
mem_to_reg  in  2  control to pass through
write_addr  in  REG_AW  destination register
ex_busy  out  1  hold PC, IF/ID and ID/EX this cycle
ex_mem_valid  out  1  EX/MEM holds a real instruction
ex_mem_alu_out, ex_mem_rt_data, ex_mem_pc_plus_4  out  DATA_W  registered results
ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write, ex_mem_fwd_mem  out  1  registered control
ex_mem_mem_to_reg  out  2  registered control
ex_mem_write_addr  out  REG_AW  registered destination
hi, lo  out  DATA_W  architectural HI/LO

Behaviour:
- Reset: all outputs, HI/LO, counter and operand latches are 0; state is IDLE.
- Forwarding priority is 10 over 01 over register. ex_mem_rt_data carries the forwarded rt value.
- Shift amounts use in1[4:0]. SLT is signed and SLTU is unsigned; both produce 0/1 zero-extended. MFHI/MFLO output hi/lo.
- Bubble = ex_mem_valid, reg_write, mem_read and mem_write all 0; data fields are don't-care.
- Single-cycle ops: EX/MEM loads on every clock edge; a bubble is loaded when id_valid=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE with id_valid, an MD op and no flush:
  - latch forwarded operands, sign flag and op; load counter with DATA_W
  - ex_busy=1 combinationally; EX/MEM gets a bubble; go to BUSY
- BUSY:
  - one shift-add (mul) or restoring-subtract (div) step per cycle on magnitudes
  - counter decrements; go to DONE when the counter reaches 1
  - ex_busy=1; EX/MEM bubble every cycle
- DONE:
  - apply sign correction; HI/LO update at the end of this cycle
  - ex_busy=0; EX/MEM loads the instruction with reg_write forced to 0 and valid=1
  - return to IDLE
- Latency: an MD op occupies EX for DATA_W+2 cycles (34 at default). A following MFHI/MFLO sees the new value with no extra stall.
- MULT/MULTU: {HI,LO} = full 2·DATA_W product.
- DIV/DIVU: LO = quotient, HI = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero: LO = all ones, HI = dividend. Signed MIN/−1: LO = MIN, HI = 0.
- flush: takes priority in every state. FSM returns to IDLE, HI/LO are unchanged, EX/MEM gets a bubble, ex_busy=0 in that cycle.
- Async reset mid-operation: immediate return to IDLE; HI/LO cleared.
- Operands are latched at entry, so changing forwarding sources during the stall have no effect.

Optional Feature:
EX_FAST_MUL_EN
- Defined: MULT/MULTU are single-cycle through a combinational multiplier. HI/LO update at the edge ending the EX cycle; ex_busy stays 0 for multiplies. DIV/DIVU are unchanged.
- Undefined: multiplies use the iterative path with DATA_W+2 cycle latency.

Test Plan:
- ADD, rs=5, rt=7, fwd_a=10 with previous ALU out 0x10 → next edge ex_mem_alu_out=0x17, valid=1.
- MULT rs=0xFFFFFFFE (−2), rt=3 → ex_busy high for 33 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; EX/MEM reg_write=0; immediate MFLO gives 0xFFFFFFFA.
- DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 → lo=0xFFFFFFFF, hi=7. DIV 0x80000000/−1 → lo=0x80000000, hi=0.
- flush asserted at BUSY cycle 10 of DIVU 100/3 → ex_busy=0 that cycle; hi/lo keep prior values; bubble in EX/MEM; a following ADD proceeds normally.
- rst_n low mid-MULTU → all outputs and hi/lo = 0 immediately; after release, SLTU 1 vs 0xFFFFFFFF → 1, and SLT of the same operands → 0.
- With EX_FAST_MUL_EN: MULTU 0xFFFFFFFF×2 → ex_busy never asserted; hi=1, lo=0xFFFFFFFE after one cycle.

Source files
------------

// File: rtl/ex_stage_md.sv
// ex_stage_md: execute stage with forwarding, single-cycle ALU and iterative mul/div feeding HI/LO.
// Define EX_FAST_MUL_EN to make MULT/MULTU single-cycle through a combinational multiplier.
module ex_stage_md #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [1:0]        fwd_a,
  input  logic [1:0]        fwd_b,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic              src1_sel,
  input  logic              src2_sel,
  input  logic [DATA_W-1:0] imm,
  input  logic [4:0]        shamt,
  input  logic [4:0]        op,
  input  logic [DATA_W-1:0] pc_plus_4,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              fwd_mem,
  input  logic [1:0]        mem_to_reg,
  input  logic [REG_AW-1:0] write_addr,
  output logic              ex_busy,
  output logic              ex_mem_valid,
  output logic [DATA_W-1:0] ex_mem_alu_out,
  output logic [DATA_W-1:0] ex_mem_rt_data,
  output logic [DATA_W-1:0] ex_mem_pc_plus_4,
  output logic              ex_mem_reg_write,
  output logic              ex_mem_mem_read,
  output logic              ex_mem_mem_write,
  output logic              ex_mem_fwd_mem,
  output logic [1:0]        ex_mem_mem_to_reg,
  output logic [REG_AW-1:0] ex_mem_write_addr,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3,
                         OP_XOR = 5'd4, OP_NOR = 5'd5, OP_SLT = 5'd6, OP_SLTU = 5'd7,
                         OP_SLL = 5'd8, OP_SRL = 5'd9, OP_SRA = 5'd10, OP_MULT = 5'd11,
                         OP_MULTU = 5'd12, OP_DIV = 5'd13, OP_DIVU = 5'd14,
                         OP_MFHI = 5'd15, OP_MFLO = 5'd16;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] fa, fb, in1, in2, alu, mag_in, mag_b, md_hi, md_lo, q_res, r_res;
  logic [DATA_W-1:0] op_a, op_b, p_hi, p_lo;
  logic [2*DATA_W-1:0] mul_res, fast_prod;
  logic [DATA_W:0] mul_sum, div_sh, div_diff;
  logic [CNT_W-1:0] cnt;
  logic is_mul, is_div, is_sgn_op, iter_op, fast_mul, start, fast_go, v_nx, md_div, md_sgn, md_neg;
  assign fa = fwd_a == 2'b10 ? ex_mem_alu_out : fwd_a == 2'b01 ? mem_fwd_data : rs_data;
  assign fb = fwd_b == 2'b10 ? ex_mem_alu_out : fwd_b == 2'b01 ? mem_fwd_data : rt_data;
  assign in1 = src1_sel ? {{(DATA_W-5){1'b0}}, shamt} : fa;
  assign in2 = src2_sel ? imm : fb;
  assign is_mul = op == OP_MULT || op == OP_MULTU;
  assign is_div = op == OP_DIV || op == OP_DIVU;
  assign is_sgn_op = op == OP_MULT || op == OP_DIV;
`ifdef EX_FAST_MUL_EN
  logic [2*DATA_W-1:0] ext_a, ext_b;
  assign ext_a = {{DATA_W{is_sgn_op & fa[DATA_W-1]}}, fa};
  assign ext_b = {{DATA_W{is_sgn_op & fb[DATA_W-1]}}, fb};
  assign fast_prod = ext_a * ext_b;
  assign iter_op = is_div;
  assign fast_mul = is_mul;
`else
  assign fast_prod = '0;
  assign iter_op = is_mul | is_div;
  assign fast_mul = 1'b0;
`endif
  assign start = state == IDLE && id_valid && iter_op && !flush;
  assign fast_go = state == IDLE && id_valid && fast_mul && !flush;
  assign ex_busy = rst_n && !flush && (start || state == BUSY);
  assign v_nx = !flush && (state == DONE || (state == IDLE && id_valid && !start));
  always_comb begin
    alu = '0;
    case (op)
      OP_ADD:  alu = in1 + in2;
      OP_SUB:  alu = in1 - in2;
      OP_AND:  alu = in1 & in2;
      OP_OR:   alu = in1 | in2;
      OP_XOR:  alu = in1 ^ in2;
      OP_NOR:  alu = ~(in1 | in2);
      OP_SLT:  alu = {{(DATA_W-1){1'b0}}, $signed(in1) < $signed(in2)};
      OP_SLTU: alu = {{(DATA_W-1){1'b0}}, in1 < in2};
      OP_SLL:  alu = in2 << in1[4:0];
      OP_SRL:  alu = in2 >> in1[4:0];
      OP_SRA:  alu = $unsigned($signed(in2) >>> in1[4:0]);
      OP_MFHI: alu = hi;
      OP_MFLO: alu = lo;
      default: alu = '0;
    endcase
  end
  // Iteration works on magnitudes; signs are restored in DONE from the latched operands.
  assign mag_in = (is_sgn_op & fa[DATA_W-1]) ? -fa : fa;
  assign mag_b = (md_sgn & op_b[DATA_W-1]) ? -op_b : op_b;
  assign mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mag_b} : '0);
  assign div_sh = {p_hi, p_lo[DATA_W-1]};
  assign div_diff = div_sh - {1'b0, mag_b};
  assign md_neg = md_sgn & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
  assign mul_res = md_neg ? -{p_hi, p_lo} : {p_hi, p_lo};
  assign q_res = op_b == '0 ? '1 : md_neg ? -p_lo : p_lo;
  assign r_res = op_b == '0 ? op_a : (md_sgn & op_a[DATA_W-1]) ? -p_hi : p_hi;
  assign md_hi = md_div ? r_res : mul_res[2*DATA_W-1:DATA_W];
  assign md_lo = md_div ? q_res : mul_res[DATA_W-1:0];
  always_comb begin
    state_nx = state;
    if (flush) state_nx = IDLE;
    else if (state == IDLE) state_nx = start ? BUSY : IDLE;
    else if (state == BUSY) state_nx = cnt == CNT_W'(1) ? DONE : BUSY;
    else state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {md_div, md_sgn, op_a, op_b, p_hi, p_lo, cnt, hi, lo} <= '0;
      {ex_mem_valid, ex_mem_alu_out, ex_mem_rt_data, ex_mem_pc_plus_4} <= '0;
      {ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write, ex_mem_fwd_mem} <= '0;
      {ex_mem_mem_to_reg, ex_mem_write_addr} <= '0;
    end else begin
      if (start) begin
        md_div <= is_div;
        md_sgn <= is_sgn_op;
        op_a <= fa;
        op_b <= fb;
        p_hi <= '0;
        p_lo <= mag_in;
        cnt <= CNT_W'(DATA_W);
      end else if (state == BUSY) begin
        cnt <= cnt - CNT_W'(1);
        p_hi <= md_div ? (div_diff[DATA_W] ? div_sh[DATA_W-1:0] : div_diff[DATA_W-1:0]) : mul_sum[DATA_W:1];
        p_lo <= md_div ? {p_lo[DATA_W-2:0], ~div_diff[DATA_W]} : {mul_sum[0], p_lo[DATA_W-1:1]};
      end
      if (state == DONE && !flush) {hi, lo} <= {md_hi, md_lo};
      else if (fast_go) {hi, lo} <= fast_prod;
      ex_mem_valid <= v_nx;
      ex_mem_reg_write <= v_nx && reg_write && state != DONE && !is_mul && !is_div;
      ex_mem_mem_read <= v_nx && mem_read;
      ex_mem_mem_write <= v_nx && mem_write;
      ex_mem_fwd_mem <= fwd_mem;
      ex_mem_mem_to_reg <= mem_to_reg;
      ex_mem_write_addr <= write_addr;
      ex_mem_alu_out <= alu;
      ex_mem_rt_data <= fb;
      ex_mem_pc_plus_4 <= pc_plus_4;
    end
  end
endmodule
